// File: rtl/qspi_pkg.sv
// Shared types for the QSPI master: FSM state encoding and the mode captured at start.
package qspi_pkg;

    localparam int MODE_DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        TRAIL
    } state_e;

    typedef struct packed {
        logic                  cpol;
        logic                  cpha;
        logic                  lsb_first;
        logic [MODE_DIV_W-1:0] clk_div;
    } mode_t;

endpackage

// File: rtl/qspi_clk_gen.sv
// SCLK edge strobe generator: one strobe every clk_div+1 cycles while run is high,
// alternating leading/trailing, restarting at a leading edge whenever run drops.
module qspi_clk_gen
    import qspi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [MODE_DIV_W-1:0] clk_div,
    output logic                  lead_stb,
    output logic                  trail_stb
);

    logic [MODE_DIV_W-1:0] cnt;
    logic                  phase;
    logic                  wrap;

    assign wrap      = run && (cnt == clk_div);
    assign lead_stb  = wrap && !phase;
    assign trail_stb = wrap && phase;

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qspi_master.sv
// SPI master with burst support and underrun stall.
// Optional feature macro: QSPI_MASTER_LSB_FIRST_EN enables LSB-first bit order.
module qspi_master
    import qspi_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 8,
    localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [15:0]           burst_len,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W);

    state_e              state, next_state;
    mode_t               mode_q;
    logic [15:0]         burst_q;
    logic [15:0]         word_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_sh;
    logic [DATA_W-1:0]   rx_sh;
    logic [DATA_W-1:0]   rx_next;
    logic                lsb_eff;
    logic                run;
    logic                lead_stb, trail_stb, edge_stb;
    logic                last_edge, word_end, more_words;
    logic                sample_stb, pop_stb;

`ifdef QSPI_MASTER_LSB_FIRST_EN
    assign lsb_eff = mode_q.lsb_first;
`else
    logic lsb_unused;
    assign lsb_eff    = 1'b0;
    assign lsb_unused = mode_q.lsb_first;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b,
                                                   input logic lsb);
        return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
    endfunction

    function automatic logic [NUM_SLAVES-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        ss_decode = '1;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (int'(sel) == i) ss_decode[i] = 1'b0;
    endfunction

    assign run        = (state == SHIFT) || (state == TRAIL);
    assign edge_stb   = lead_stb || trail_stb;
    assign last_edge  = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
    assign word_end   = (state == SHIFT) && trail_stb && last_edge;
    assign more_words = ({1'b0, word_cnt} + 17'd1) < {1'b0, burst_q};
    assign rx_next    = shift_in(rx_sh, miso, lsb_eff);
    // cpha=0 presents bit 0 at load and shifts on trailing edges; cpha=1 shifts on leading edges.
    assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
    assign pop_stb    = mode_q.cpha ? lead_stb : (trail_stb && !last_edge);
    assign busy       = (state != IDLE);

    qspi_clk_gen u_clk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .clk_div   (mode_q.clk_div),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // tx handshake: a word transfers in the cycle where tx_valid and tx_ready are both high;
    // tx_ready is only raised in LOAD, so tx_valid elsewhere has no effect.
    always_comb begin
        next_state = state;
        tx_ready   = 1'b0;
        case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD: begin
                if (tx_valid) begin
                    tx_ready   = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: if (word_end) next_state = more_words ? LOAD : TRAIL;
            TRAIL: if (edge_stb) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= '0;
            burst_q  <= '0;
            word_cnt <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    mosi <= 1'b0;
                    sclk <= mode_q.cpol;
                    if (start) begin
                        mode_q   <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first,
                                      clk_div: MODE_DIV_W'(clk_div)};
                        sclk     <= cpol;
                        burst_q  <= (burst_len == 16'd0) ? 16'd1 : burst_len;
                        word_cnt <= '0;
                        edge_cnt <= '0;
                        ss_n     <= ss_decode(slave_sel);
                    end
                end
                LOAD: begin
                    if (tx_valid) begin
                        if (!mode_q.cpha) begin
                            mosi  <= first_bit(tx_data, lsb_eff);
                            tx_sh <= shift_out(tx_data, lsb_eff);
                        end else begin
                            tx_sh <= tx_data;
                        end
                    end
                end
                SHIFT: begin
                    if (edge_stb) begin
                        sclk     <= ~sclk;
                        edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
                    end
                    if (sample_stb) rx_sh <= rx_next;
                    if (pop_stb) begin
                        mosi  <= first_bit(tx_sh, lsb_eff);
                        tx_sh <= shift_out(tx_sh, lsb_eff);
                    end
                    if (word_end) begin
                        rx_valid <= 1'b1;
                        rx_data  <= mode_q.cpha ? rx_next : rx_sh;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (edge_stb) begin
                        ss_n <= '1;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_master.sv
// Directed bench for qspi_master: driver tasks push expected rx words, a monitor pops and compares.
module tb_qspi_master;

    localparam int NS  = 3;
    localparam int DW  = 8;
    localparam int DVW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [DVW-1:0] clk_div = '0;
    logic [1:0]    slave_sel = '0;
    logic [15:0]   burst_len = '0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, done, sclk, mosi, miso;
    logic [NS-1:0] ss_n;
    logic          miso_loop = 1'b1, miso_val = 1'b0;

    int            checks = 0, errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [NS-1:0] exp_ss = '1;

    int            cyc = 0, edge_tot = 0, rxv_tot = 0, done_tot = 0, ss_bad_tot = 0;
    int            gap_min = 0, gap_max = 0, last_tog = -1;
    logic [7:0]    mosi_cap = '0;
    logic          prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [DW-1:0] mon_e;

    qspi_master #(.NUM_SLAVES(NS), .DATA_W(DW), .DIV_W(DVW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .slave_sel(slave_sel), .burst_len(burst_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
        .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;
    assign miso = miso_loop ? mosi : miso_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on rx_valid; also tallies SCLK edges, pulses and ss_n behaviour.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (rx_valid) begin
                    rxv_tot++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(mon_e));
                    end
                end
                if (done) done_tot++;
                if (busy && !prev_busy) begin
                    gap_min  = 1000;
                    gap_max  = 0;
                    last_tog = -1;
                    mosi_cap = '0;
                end
                if (busy && ss_n !== exp_ss) ss_bad_tot++;
                if (prev_busy && sclk !== prev_sclk) begin
                    edge_tot++;
                    if (last_tog >= 0) begin
                        if (cyc - last_tog < gap_min) gap_min = cyc - last_tog;
                        if (cyc - last_tog > gap_max) gap_max = cyc - last_tog;
                    end
                    last_tog = cyc;
                    if (sclk === 1'b1) mosi_cap = {mosi_cap[6:0], mosi};
                end
            end
            prev_sclk = sclk;
            prev_busy = busy;
        end
    end

    task automatic xfer(input string tag, input logic c_pol, input logic c_pha, input logic lsb,
                        input logic [7:0] div, input logic [1:0] sel, input logic [15:0] blen,
                        input int nw, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input int stall);
        logic [7:0] tw[3];
        logic [7:0] rw[3];
        int e0, v0, d0, s0, sbad;
        bit ok;
        tw = '{w0, w1, w2};
        rw = '{r0, r1, r2};
        for (int i = 0; i < nw; i++) exp_q.push_back(rw[i]);
        e0 = edge_tot; v0 = rxv_tot; d0 = done_tot; s0 = ss_bad_tot;
        @(negedge clk);
        cpol = c_pol; cpha = c_pha; lsb_first = lsb; clk_div = div;
        slave_sel = sel; burst_len = blen; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            if (i > 0 && stall > 0) begin
                ok = 0;
                for (int k = 0; k < 4000; k++) begin
                    if (rx_valid) begin ok = 1; break; end
                    @(negedge clk);
                end
                check({tag, "_rx_wait"}, 32'(ok), 32'd1);
                sbad = 0;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    if (sclk !== c_pol) sbad++;
                    if (busy !== 1'b1) sbad++;
                end
                check({tag, "_stall_frozen"}, 32'(sbad), 32'd0);
            end
            tx_data  = tw[i];
            tx_valid = 1'b1;
            ok = 0;
            for (int k = 0; k < 4000; k++) begin
                #1;
                if (tx_ready) begin ok = 1; break; end
                @(negedge clk);
            end
            check({tag, "_tx_handshake"}, 32'(ok), 32'd1);
            @(negedge clk);
            tx_valid = 1'b0;
            if (i == 0) begin
                // A start with different settings mid-transfer must change nothing.
                start = 1'b1; cpol = ~c_pol; clk_div = '0; slave_sel = '0;
                @(negedge clk);
                start = 1'b0;
            end
        end
        ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ss_n"}, 32'(ss_n), 32'h7);
        @(negedge clk);
        check({tag, "_edges"}, 32'(edge_tot - e0), 32'(16 * nw));
        check({tag, "_rx_pulses"}, 32'(rxv_tot - v0), 32'(nw));
        check({tag, "_done_pulses"}, 32'(done_tot - d0), 32'd1);
        check({tag, "_ss_held"}, 32'(ss_bad_tot - s0), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'h7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, fastest clock, loopback.
        exp_ss = 3'b110; miso_loop = 1'b1;
        xfer("m0", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 16'd1, 1, 8'hA5, 8'h00, 8'h00,
             8'hA5, 8'h00, 8'h00, 0);
        check("m0_mosi_bits", 32'(mosi_cap), 32'hA5);

        // Mode 3, half-period of 4 cycles, miso tied high.
        exp_ss = 3'b101; miso_loop = 1'b0; miso_val = 1'b1;
        xfer("m3", 1'b1, 1'b1, 1'b0, 8'd3, 2'd1, 16'd1, 1, 8'h3C, 8'h00, 8'h00,
             8'hFF, 8'h00, 8'h00, 0);
        check("m3_gap_min", 32'(gap_min), 32'd4);
        check("m3_gap_max", 32'(gap_max), 32'd4);
        check("m3_idle_sclk", 32'(sclk), 32'd1);

        // Burst of three with an underrun before the second word.
        exp_ss = 3'b011; miso_loop = 1'b1;
        xfer("burst", 1'b1, 1'b0, 1'b0, 8'd1, 2'd2, 16'd3, 3, 8'h11, 8'h22, 8'h33,
             8'h11, 8'h22, 8'h33, 10);

        // Bit order with a single set bit; burst_len 0 behaves as 1.
        exp_ss = 3'b110; miso_loop = 1'b1;
        xfer("order", 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 16'd0, 1, 8'h01, 8'h00, 8'h00,
             8'h01, 8'h00, 8'h00, 0);
`ifdef QSPI_MASTER_LSB_FIRST_EN
        check("order_mosi_bits", 32'(mosi_cap), 32'h80);
`else
        check("order_mosi_bits", 32'(mosi_cap), 32'h01);
`endif

        // Reset mid-word, then a transfer to a non-existent slave.
        exp_ss = 3'b110;
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd2;
        slave_sel = 2'd0; burst_len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd0);
        check("midrst_ss_n", 32'(ss_n), 32'h7);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        exp_ss = 3'b111;
        xfer("nosel", 1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 16'd1, 1, 8'h5A, 8'h00, 8'h00,
             8'h5A, 8'h00, 8'h00, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_master.md
QSPI_MASTER -- requirements
Module: qspi_master

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 2: number of slave-select lines (1..32).
REQ-002 SHALL have parameter DATA_W, default 8: word width in bits (2..32).
REQ-003 SHALL have parameter DIV_W, default 8: width of the clock-divider input.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  transaction request; accepted only in IDLE.
- cpol  in  1  idle SCLK level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- lsb_first  in  1  bit order select.
- clk_div  in  DIV_W  SCLK half-period minus 1, in clk cycles.
- slave_sel  in  max(1,$clog2(NUM_SLAVES))  slave index.
- burst_len  in  16  words per transaction; 0 is treated as 1.
- tx_data  in  DATA_W  outgoing word.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-cycle pulse when tx_data is consumed.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when returning to IDLE.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- ss_n  out  NUM_SLAVES  active-low slave selects.

Function
REQ-005 SHALL latch cpol, cpha, lsb_first, clk_div, slave_sel and burst_len on accepting start, and ignore later changes to them until IDLE.
REQ-006 SHALL implement states IDLE -> LOAD -> SHIFT -> (LOAD | TRAIL) -> IDLE.
REQ-007 IDLE: sclk = latched cpol, mosi = 0, ss_n all 1. On start, SHALL go to LOAD and assert ss_n[slave_sel] = 0 on the next cycle.
REQ-008 LOAD: ss stays asserted, sclk stays at cpol. In the first cycle with tx_valid = 1, SHALL pulse tx_ready, load the shift register and go to SHIFT. Without tx_valid, LOAD SHALL stall indefinitely (underrun stall).
REQ-009 SHALL toggle SCLK every clk_div+1 clk cycles in SHIFT, giving exactly 2*DATA_W edges per word, with the first edge clk_div+1 cycles after entering SHIFT.
REQ-010 cpha = 0: first bit SHALL be on mosi in the load cycle; miso sampled on leading edges; mosi updated on trailing edges except the last.
REQ-011 cpha = 1: mosi updated on leading edges; miso sampled on trailing edges.
REQ-012 Bit order: MSB first when lsb_first = 0, LSB first when lsb_first = 1. rx_data SHALL be assembled in the same order.
REQ-013 On the final edge of a word, SHALL pulse rx_valid with the complete rx_data in the following cycle and increment the word counter.
REQ-014 At the end of a word: if the word count is below burst_len, SHALL go to LOAD with ss held asserted; otherwise go to TRAIL.
REQ-015 TRAIL: ss SHALL stay asserted for clk_div+1 cycles, then ss_n all 1, done pulse, and return to IDLE.
REQ-016 An out-of-range slave_sel SHALL assert no ss_n line; the transfer otherwise proceeds normally.
REQ-017 start while busy SHALL be ignored. tx_valid outside LOAD SHALL be ignored.

Reset
REQ-018 reset_n = 0 at any clock edge, including mid-transfer, SHALL force IDLE with: sclk = 0, mosi = 0, ss_n all 1, tx_ready = 0, rx_valid = 0, done = 0, busy = 0, rx_data = 0, counters = 0, latched cpol = 0.

Configuration
REQ-019 With macro QSPI_MASTER_LSB_FIRST_EN defined, lsb_first SHALL be honoured per REQ-012. Without it, the lsb_first port SHALL remain present but be ignored, and transfers SHALL always be MSB first.

Structure
REQ-020 Package qspi_pkg SHALL hold the state enum (IDLE, LOAD, SHIFT, TRAIL) and the latched-mode struct (cpol, cpha, lsb_first, clk_div).
REQ-021 Sub-module qspi_clk_gen SHALL produce leading/trailing edge strobes from clk_div; the shift logic stays in qspi_master.

Verification
REQ-022 Mode 0, DATA_W = 8, clk_div = 0, burst_len = 1, tx 0xA5, miso loopback -> rx_data 0xA5, 16 sclk edges, ss low for the whole word.
REQ-023 Mode 3, clk_div = 3, tx 0x3C, miso tied 1 -> sclk idle high, half-period 4 clk cycles, rx_data 0xFF.
REQ-024 burst_len = 3, tx 0x11/0x22/0x33 with tx_valid withheld 10 cycles before the 2nd word -> ss stays low throughout, sclk frozen at cpol during the stall, 3 rx_valid pulses, 1 done pulse.
REQ-025 With QSPI_MASTER_LSB_FIRST_EN and lsb_first = 1, tx 0x01 -> mosi high on the first bit only. Without the macro -> mosi high on the last bit only.
REQ-026 reset_n = 0 mid-word, then start with slave_sel = NUM_SLAVES -> immediate IDLE outputs per REQ-018; the new transfer completes with ss_n all 1.
